// File: rtl/mmio_event_counters_if.sv
// MMIO bus bundle between the CPU decode and the event counter bank.
// Single-cycle strobes with registered read data.
interface mmio_event_counters_if;
    logic [7:0]  mmio_addr;
    logic        mmio_wen;
    logic [31:0] mmio_wdata;
    logic        mmio_ren;
    logic [31:0] mmio_rdata;

    modport master (
        output mmio_addr,
        output mmio_wen,
        output mmio_wdata,
        output mmio_ren,
        input  mmio_rdata
    );

    modport slave (
        input  mmio_addr,
        input  mmio_wen,
        input  mmio_wdata,
        input  mmio_ren,
        output mmio_rdata
    );
endinterface

// File: rtl/mmio_event_counters.sv
// Bank of memory-mapped event counters with clear, freeze,
// atomic snapshot and sticky overflow flags driving an interrupt.
module mmio_event_counters #(
    parameter int NUM_COUNTERS  = 4,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_COUNTERS-1:0] event_inc,
    mmio_event_counters_if.slave    bus,
    output logic                    overflow_irq
);

    typedef logic [COUNTER_WIDTH-1:0] cnt_t;

    cnt_t                    cnt_q [NUM_COUNTERS];
    cnt_t                    cnt_d [NUM_COUNTERS];
    cnt_t                    shd_q [NUM_COUNTERS];
    cnt_t                    shd_d [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0] ovf_q;
    logic [NUM_COUNTERS-1:0] ovf_d;
    logic                    en_q;
    logic                    en_d;
    logic                    frz_q;
    logic                    frz_d;
    logic                    ie_q;
    logic                    ie_d;
    logic [31:0]             rdata_q;
    logic [31:0]             rdata_d;

    logic [1:0]  region;
    logic [3:0]  idx;
    logic        ctl_sel;
    logic        wr_ctrl;
    logic        wr_clr;
    logic        wr_ovf;
    logic        wr_snap;
    logic        cnt_ok;
    logic        inc;
    logic        clr;
    logic [31:0] rd_val;
    logic        unused;

    assign region  = bus.mmio_addr[7:6];
    assign idx     = bus.mmio_addr[5:2];
    assign ctl_sel = bus.mmio_wen && (region == 2'b00);
    assign wr_ctrl = ctl_sel && (idx == 4'h0);
    assign wr_clr  = ctl_sel && (idx == 4'h1);
    assign wr_ovf  = ctl_sel && (idx == 4'h2);
    assign wr_snap = ctl_sel && (idx == 4'h3);
    assign cnt_ok  = en_q && !frz_q;
    assign unused  = ^{bus.mmio_addr[1:0], bus.mmio_wdata};

    always_comb begin
        en_d  = en_q;
        frz_d = frz_q;
        ie_d  = ie_q;
        cnt_d = cnt_q;
        shd_d = shd_q;
        ovf_d = ovf_q;
        inc   = 1'b0;
        clr   = 1'b0;
        if (wr_ctrl) begin
            en_d  = bus.mmio_wdata[0];
            frz_d = bus.mmio_wdata[1];
            ie_d  = bus.mmio_wdata[2];
        end
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            inc = event_inc[i] && cnt_ok;
            clr = wr_clr && bus.mmio_wdata[i];
            if (clr) begin
                cnt_d[i] = '0;
            end else if (inc) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
            // a fresh overflow beats a simultaneous W1C
            ovf_d[i] = (inc && !clr && (&cnt_q[i]))
                     || (ovf_q[i] && !(wr_ovf && bus.mmio_wdata[i]));
            if (wr_snap) begin
                shd_d[i] = cnt_q[i];
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (region)
            2'b00: begin
                case (idx)
                    4'h0:    rd_val[2:0] = {ie_q, frz_q, en_q};
                    4'h2:    rd_val[NUM_COUNTERS-1:0] = ovf_q;
                    default: rd_val = '0;
                endcase
            end
            2'b01: begin
                for (int i = 0; i < NUM_COUNTERS; i++) begin
                    if (idx == 4'(i)) begin
                        rd_val[COUNTER_WIDTH-1:0] = cnt_q[i];
                    end
                end
            end
            2'b10: begin
                for (int i = 0; i < NUM_COUNTERS; i++) begin
                    if (idx == 4'(i)) begin
                        rd_val[COUNTER_WIDTH-1:0] = shd_q[i];
                    end
                end
            end
            default: rd_val = '0;
        endcase
        rdata_d = bus.mmio_ren ? rd_val : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                cnt_q[i] <= '0;
                shd_q[i] <= '0;
            end
            ovf_q   <= '0;
            en_q    <= 1'b1;
            frz_q   <= 1'b0;
            ie_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                cnt_q[i] <= cnt_d[i];
                shd_q[i] <= shd_d[i];
            end
            ovf_q   <= ovf_d;
            en_q    <= en_d;
            frz_q   <= frz_d;
            ie_q    <= ie_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.mmio_rdata = rdata_q;
    assign overflow_irq   = ie_q && (|ovf_q);

endmodule

// File: doc/mmio_event_counters.md
# mmio_event_counters

Parametrised bank of memory-mapped event counters for the Riscv151 memory-mapped I/O region, generalising the fixed cycle/instruction counter pair. The bank provides:
- NUM_COUNTERS independent counters with per-channel clear;
- a global enable/freeze;
- an atomic snapshot of all counters into shadow registers;
- sticky overflow flags with an interrupt output.

It sits behind the CPU's MMIO decode. The CPU supplies word-aligned offsets within its window.

## Interface
- NUM_COUNTERS, default 4: number of counter channels, legal range 1..16.
- COUNTER_WIDTH, default 32: counter width in bits, legal range 1..32. Reads are zero-extended to 32 bits.
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- event_inc  input  NUM_COUNTERS  bit i high for one cycle increments counter i by 1. By convention, channel 0 is tied high (cycle counter) and channel 1 is instruction-retired.
- mmio_addr  input  8  byte offset within the window; bits [1:0] are ignored.
- mmio_wen  input  1  write strobe.
- mmio_wdata  input  32  write data.
- mmio_ren  input  1  read strobe.
- mmio_rdata  output  32  registered read data.
- overflow_irq  output  1  high while irq_en=1 and any overflow flag is set.

## Operation
Register map (word offsets):
- 0x00 CTRL, read/write: bit0 enable (reset 1), bit1 freeze (reset 0), bit2 irq_en (reset 0). Other bits read 0.
- 0x04 CLEAR, write-only: bit i=1 zeroes counter i. Reads return 0.
- 0x08 OVF, write-1-to-clear: bit i is the sticky overflow flag of counter i.
- 0x0C SNAP, write-only, any data: copies every live counter into its shadow register in the same edge. Reads return 0.
- 0x40+4*i: live counter i. Writes are ignored.
- 0x80+4*i: shadow counter i. Writes are ignored.
- Unmapped offsets, and indices i ≥ NUM_COUNTERS: reads return 0, writes are ignored.

Counting:
- Counter i increments when event_inc[i]=1, enable=1 and freeze=0. Otherwise it holds, and the event is dropped, not queued.
- Arithmetic is modulo 2^COUNTER_WIDTH. The increment from all-ones wraps to 0 and sets OVF[i] in the same edge.

Simultaneous-event priorities:
- CLEAR[i] and an increment of counter i in the same cycle: clear wins, counter = 0, and no overflow is recorded.
- New overflow and W1C of the same OVF bit in the same cycle: set wins.
- SNAP and an increment in the same cycle: the shadow captures the pre-increment value.
- CLEAR and SNAP cannot coincide, because there is only one write per cycle.
- mmio_ren and mmio_wen to the same register in the same cycle: the read returns the pre-write value.

Interrupt:
- overflow_irq = irq_en & (|OVF).
- It is derived only from registers, so no combinational path exists from the inputs.

## Timing
- Reset (asynchronous assert): all counters 0, all shadows 0, OVF 0, CTRL = 0x1, mmio_rdata = 0, overflow_irq = 0.
- Write side effects are visible on live-counter reads issued the cycle after the write. For example, a CLEAR at edge N followed by a read at N+1 returns 0 plus any increments counted at N+1.
- Read latency is 1 cycle:
  - mmio_rdata is updated on the edge where mmio_ren=1.
  - The value is the register state before that edge.
  - mmio_rdata holds its value until the next read.
- Counter update, overflow set and snapshot all complete in one edge. There is no multi-cycle state.
- Reset asserted mid-operation: all state returns to reset values immediately. Events during reset are not counted.
- Reset release: counting resumes on the first rising edge with rst low.

## Test plan
- Reset, then hold event_inc[0]=1 for 20 cycles, then read 0x40 -> mmio_rdata = 20 on the cycle after the read edge. Read 0x00 -> 0x1.
- Pulse event_inc[1] 7 times. Write CLEAR=0x2 in the same cycle as an event_inc[1] pulse. Read 0x44 next cycle -> 0. Read 0x40 -> still counting, unaffected.
- Write SNAP while channel 0 is counting. Read 0x80 twice, 5 cycles apart -> identical values equal to the live count at the SNAP edge. Read 0x40 -> a larger value.
- COUNTER_WIDTH=4: 16 increments on channel 2 -> 0x48 reads 0 and OVF reads 0x4.
  - overflow_irq stays 0 until CTRL=0x5 is written, then goes 1.
  - Write OVF=0x4 -> irq falls the next cycle.
  - A W1C coincident with a new overflow leaves the bit set.
- Set CTRL=0x3 (freeze) for 10 cycles with all events high -> counters unchanged. Set CTRL=0x1 -> counting resumes from the held values.
- Read 0xC0 and 0x40+4*NUM_COUNTERS -> 0. Write 0x40 -> counter unchanged. Assert rst asynchronously mid-count -> all outputs are 0 before the next clock edge.
